// File: rtl/bar_chart_sequencer_pkg.sv
// Shared definitions for the bar chart sequencer: FSM state encoding, screen limits,
// default colours and the height clamp helper.
package bar_chart_sequencer_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int BAR_W    = 32;

   localparam logic [2:0] DEF_BAR_COLOUR = 3'b010;
   localparam logic [2:0] DEF_BG_COLOUR  = 3'b000;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_CLEAR = 4'd1,
      ST_FETCH = 4'd2,
      ST_LATCH = 4'd3,
      ST_LOAD  = 4'd4,
      ST_DRAW  = 4'd5,
      ST_NEXT  = 4'd6,
      ST_DONE  = 4'd7
   } state_t;

   function automatic logic [6:0] clamp_height(input logic [6:0] i_h, input logic [6:0] i_max);
      clamp_height = (i_h > i_max) ? i_max : i_h;
   endfunction

endpackage

// File: rtl/bar_chart_sequencer_clear_sweep.sv
// Rectangle raster counter used to blank the chart region: x runs inner, y outer,
// o_last flags the bottom-right pixel of the rectangle.
module bar_chart_sequencer_clear_sweep (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic [8:0] i_x0,
   input  logic [7:0] i_y0,
   input  logic [8:0] i_w,
   input  logic [7:0] i_h,
   output logic [8:0] o_x,
   output logic [7:0] o_y,
   output logic       o_last
);

   logic [8:0] r_cx;
   logic [7:0] r_cy;
   logic       w_row_end;

   assign w_row_end = (r_cx == (i_w - 9'd1));
   assign o_last    = w_row_end && (r_cy == (i_h - 8'd1));
   assign o_x       = i_x0 + r_cx;
   assign o_y       = i_y0 + r_cy;

   // Raster position; wraps to the origin after the last pixel
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_cx <= 9'd0;
         r_cy <= 8'd0;
      end else if (i_clr) begin
         r_cx <= 9'd0;
         r_cy <= 8'd0;
      end else if (i_en) begin
         if (w_row_end) begin
            r_cx <= 9'd0;
            r_cy <= o_last ? 8'd0 : (r_cy + 8'd1);
         end else begin
            r_cx <= r_cx + 9'd1;
         end
      end else begin
         r_cx <= r_cx;
         r_cy <= r_cy;
      end
   end

endmodule

// File: rtl/bar_chart_sequencer.sv
// Chart sequencer: blanks the chart region, then loads and runs an external bar drawer once per
// history entry, muxing blanking or drawer pixels onto a single registered VGA plot interface.
module bar_chart_sequencer
   import bar_chart_sequencer_pkg::*;
#(
   parameter int                  NUM_BARS   = 8,
   parameter int                  BAR_PITCH  = 40,
   parameter int                  CHART_X0   = 0,
   parameter int                  BASE_Y     = 200,
   parameter int                  MAX_H      = 100,
   parameter int                  COLOUR_W   = 3,
   parameter logic [COLOUR_W-1:0] BAR_COLOUR = COLOUR_W'(DEF_BAR_COLOUR),
   parameter logic [COLOUR_W-1:0] BG_COLOUR  = COLOUR_W'(DEF_BG_COLOUR),
   localparam int                 AW         = $clog2(NUM_BARS)
) (
   input  logic                i_clk,
   input  logic                i_resetn,
   input  logic                i_start,
   output logic [AW-1:0]       o_hist_addr,
   input  logic [6:0]          i_hist_data,
   output logic                o_drw_rst_n,
   output logic [8:0]          o_drw_start_x,
   output logic [7:0]          o_drw_start_y,
   output logic [6:0]          o_drw_height,
   output logic                o_drw_enable,
   input  logic [8:0]          i_drw_x,
   input  logic [7:0]          i_drw_y,
   input  logic                i_drw_done,
   output logic [8:0]          o_vga_x,
   output logic [7:0]          o_vga_y,
   output logic [COLOUR_W-1:0] o_vga_colour,
   output logic                o_vga_plot,
   output logic                o_busy,
   output logic                o_done
);

   if ((BASE_Y < MAX_H) || (BASE_Y >= SCREEN_H) || (BAR_W > BAR_PITCH) ||
       (CHART_X0 + NUM_BARS * BAR_PITCH > SCREEN_W)) begin : g_bad_geometry
      $error("bar_chart_sequencer: chart geometry does not fit the screen");
   end

   state_t                r_state;
   logic [AW-1:0]         r_idx;
   logic [6:0]            r_h;
   logic [8:0]            r_sx;
   logic [7:0]            r_sy;
   logic                  r_drw_rst_n;
   logic                  r_drw_en;
   logic                  r_plot;
   logic [8:0]            r_vx;
   logic [7:0]            r_vy;
   logic [COLOUR_W-1:0]   r_col;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_clr_restart;
   logic                  w_clr_en;
   logic [8:0]            w_clr_x;
   logic [7:0]            w_clr_y;
   logic                  w_clr_last;
   logic [6:0]            w_h_clamp;

   assign w_clr_restart = (r_state == ST_IDLE) && i_start;
   assign w_clr_en      = (r_state == ST_CLEAR);
   assign w_h_clamp     = clamp_height(i_hist_data, 7'(MAX_H));

   bar_chart_sequencer_clear_sweep u_clear_sweep (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_clr    (w_clr_restart),
      .i_en     (w_clr_en),
      .i_x0     (9'(CHART_X0)),
      .i_y0     (8'(BASE_Y - MAX_H)),
      .i_w      (9'(NUM_BARS * BAR_PITCH)),
      .i_h      (8'(MAX_H + 1)),
      .o_x      (w_clr_x),
      .o_y      (w_clr_y),
      .o_last   (w_clr_last)
   );

   // Sequencer FSM with all outputs registered; the drawer is held cleared outside DRAW
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_h         <= 7'd0;
         r_sx        <= 9'd0;
         r_sy        <= 8'd0;
         r_drw_rst_n <= 1'b0;
         r_drw_en    <= 1'b0;
         r_plot      <= 1'b0;
         r_vx        <= 9'd0;
         r_vy        <= 8'd0;
         r_col       <= BG_COLOUR;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_plot <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
                  r_idx   <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               r_plot  <= 1'b1;
               r_vx    <= w_clr_x;
               r_vy    <= w_clr_y;
               r_col   <= BG_COLOUR;
               r_state <= w_clr_last ? ST_FETCH : ST_CLEAR;
            end
            // hist_addr follows r_idx, so the RAM address is already valid in FETCH
            ST_FETCH: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_h     <= w_h_clamp;
               r_sx    <= 9'(CHART_X0 + int'(r_idx) * BAR_PITCH);
               r_sy    <= 8'(BASE_Y - int'(w_h_clamp));
               r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_drw_rst_n <= 1'b1;
               r_drw_en    <= 1'b1;
               r_state     <= ST_DRAW;
            end
            ST_DRAW: begin
               r_plot <= 1'b1;
               r_vx   <= i_drw_x;
               r_vy   <= i_drw_y;
               r_col  <= BAR_COLOUR;
               if (i_drw_done) begin
                  r_drw_rst_n <= 1'b0;
                  r_drw_en    <= 1'b0;
                  r_state     <= ST_NEXT;
               end else begin
                  r_state <= ST_DRAW;
               end
            end
            ST_NEXT: begin
               if (r_idx == AW'(NUM_BARS - 1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + AW'(1);
                  r_state <= ST_FETCH;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_drw_rst_n <= 1'b0;
               r_drw_en    <= 1'b0;
            end
         endcase
      end
   end

   assign o_hist_addr   = r_idx;
   assign o_drw_rst_n   = r_drw_rst_n;
   assign o_drw_start_x = r_sx;
   assign o_drw_start_y = r_sy;
   assign o_drw_height  = r_h;
   assign o_drw_enable  = r_drw_en;
   assign o_vga_x       = r_vx;
   assign o_vga_y       = r_vy;
   assign o_vga_colour  = r_col;
   assign o_vga_plot    = r_plot;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule

// File: tb/tb_bar_chart_sequencer.sv
// Self-checking bench for bar_chart_sequencer with a history RAM model, a bar drawer model,
// a pixel scoreboard and a framebuffer compared against a golden chart image.
module tb_bar_chart_sequencer;

   typedef struct {
      int         addr;
      logic [6:0] hist;
      int         exp_sx;
      int         exp_sy;
      int         exp_h;
      int         exp_plots;
   } vec_t;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [2:0] hist_addr;
   logic [6:0] hist_data;
   logic       drw_rst_n;
   logic [8:0] drw_start_x;
   logic [7:0] drw_start_y;
   logic [6:0] drw_height;
   logic       drw_enable;
   logic [8:0] drw_x;
   logic [7:0] drw_y;
   logic       drw_done;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] mem [0:7];
   vec_t       vecs [0:7];
   pix_t       sbq [$];
   logic [2:0] fb [0:319][0:100];

   int cyc = 0;
   int pix_err, reg_err, bg_plots, bar_seen, done_cnt, done_cyc;
   int bar_plots [0:7];
   int cap_sx [0:7];
   int cap_sy [0:7];
   int cap_h  [0:7];
   logic prev_drw;

   logic [4:0] dcx;
   logic [6:0] dcy;
   logic [8:0] dsx;
   logic [7:0] dsy;
   logic [6:0] dh;

   bar_chart_sequencer dut (
      .i_clk         (clk),
      .i_resetn      (resetn),
      .i_start       (start),
      .o_hist_addr   (hist_addr),
      .i_hist_data   (hist_data),
      .o_drw_rst_n   (drw_rst_n),
      .o_drw_start_x (drw_start_x),
      .o_drw_start_y (drw_start_y),
      .o_drw_height  (drw_height),
      .o_drw_enable  (drw_enable),
      .i_drw_x       (drw_x),
      .i_drw_y       (drw_y),
      .i_drw_done    (drw_done),
      .o_vga_x       (vga_x),
      .o_vga_y       (vga_y),
      .o_vga_colour  (vga_colour),
      .o_vga_plot    (vga_plot),
      .o_busy        (busy),
      .o_done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous history RAM: data one cycle after address
   always @(posedge clk) hist_data <= mem[hist_addr];

   // bar drawer model: latches coords while held in reset, 32-px rows top to bottom
   always @(posedge clk) begin
      if (!drw_rst_n) begin
         dcx <= 5'd0;
         dcy <= 7'd0;
         dsx <= drw_start_x;
         dsy <= drw_start_y;
         dh  <= drw_height;
      end else if (drw_enable) begin
         if (dcx == 5'd31) begin
            dcx <= 5'd0;
            dcy <= dcy + 7'd1;
         end else begin
            dcx <= dcx + 5'd1;
         end
      end
   end
   assign drw_x    = dsx + 9'(dcx);
   assign drw_y    = dsy + 8'(dcy);
   assign drw_done = drw_rst_n && (dcx == 5'd31) && (dcy == dh);

   // output monitor: scoreboard pop, region check, framebuffer, per-bar capture
   always @(negedge clk) begin : mon
      pix_t got_p;
      pix_t exp_p;
      got_p = {vga_x, vga_y, vga_colour};
      if (vga_plot) begin
         if (sbq.size() == 0) begin
            pix_err <= pix_err + 1;
         end else begin
            exp_p = sbq.pop_front();
            if (exp_p != got_p) pix_err <= pix_err + 1;
         end
         if (vga_x >= 9'd320 || vga_y < 8'd100 || vga_y > 8'd200) reg_err <= reg_err + 1;
         else fb[vga_x][vga_y - 8'd100] <= vga_colour;
         if (vga_colour == 3'b000) bg_plots <= bg_plots + 1;
         else if (bar_seen > 0 && bar_seen <= 8) bar_plots[bar_seen-1] <= bar_plots[bar_seen-1] + 1;
      end
      if (drw_rst_n && !prev_drw) begin
         if (bar_seen < 8) begin
            cap_sx[bar_seen] <= int'(drw_start_x);
            cap_sy[bar_seen] <= int'(drw_start_y);
            cap_h[bar_seen]  <= int'(drw_height);
         end
         bar_seen <= bar_seen + 1;
      end
      prev_drw <= drw_rst_n;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      pix_err  = 0;
      reg_err  = 0;
      bg_plots = 0;
      bar_seen = 0;
      done_cnt = 0;
      done_cyc = 0;
      prev_drw = 1'b0;
      for (int i = 0; i < 8; i++) bar_plots[i] = 0;
      sbq.delete();
   endtask

   function automatic int clamp_model(input logic [6:0] h);
      return (h > 7'd100) ? 100 : int'(h);
   endfunction

   // expected plot stream: full blanking raster, then each bar row by row
   task automatic push_chart();
      int h;
      for (int y = 100; y <= 200; y++)
         for (int x = 0; x < 320; x++)
            sbq.push_back({9'(x), 8'(y), 3'b000});
      for (int b = 0; b < 8; b++) begin
         h = clamp_model(mem[b]);
         for (int y = 200 - h; y <= 200; y++)
            for (int x = b * 40; x < b * 40 + 32; x++)
               sbq.push_back({9'(x), 8'(y), 3'b010});
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_hist_addr"},  int'(hist_addr),  0);
      check({tag, "_drw_rst_n"},  int'(drw_rst_n),  0);
      check({tag, "_drw_enable"}, int'(drw_enable), 0);
      check({tag, "_drw_height"}, int'(drw_height), 0);
      check({tag, "_vga_plot"},   int'(vga_plot),   0);
      check({tag, "_vga_x"},      int'(vga_x),      0);
      check({tag, "_vga_y"},      int'(vga_y),      0);
      check({tag, "_vga_colour"}, int'(vga_colour), 0);
      check({tag, "_busy"},       int'(busy),       0);
      check({tag, "_done"},       int'(done),       0);
   endtask

   task automatic pulse_start(output int at_cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      at_cyc = cyc;
   endtask

   initial begin
      int start_cyc;
      int dummy_cyc;
      int exp_len;
      int fb_bad;
      logic [2:0] gold;
      int b;

      vecs[0] = '{0, 7'd0,   0,   200, 0,   32};
      vecs[1] = '{1, 7'd5,   40,  195, 5,   192};
      vecs[2] = '{2, 7'd2,   80,  198, 2,   96};
      vecs[3] = '{3, 7'd10,  120, 190, 10,  352};
      vecs[4] = '{4, 7'd127, 160, 100, 100, 3232};
      vecs[5] = '{5, 7'd3,   200, 197, 3,   128};
      vecs[6] = '{6, 7'd100, 240, 100, 100, 3232};
      vecs[7] = '{7, 7'd1,   280, 199, 1,   64};

      resetn = 1'b0;
      start  = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 7'd0;
      clear_stats();
      repeat (3) tick();
      check_reset("por");
      resetn = 1'b1;
      tick();

      // Run A: all heights zero, abandoned by reset during bar 5
      push_chart();
      pulse_start(start_cyc);
      check("runA_busy", int'(busy), 1);
      for (int k = 0; k < 40000 && bar_seen < 6; k++) tick();
      check("runA_reach_bar5", (bar_seen >= 6) ? 1 : 0, 1);
      check("runA_hist_addr_bar5", int'(hist_addr), 5);
      repeat (4) tick();
      check("runA_in_draw_plot", int'(vga_plot), 1);
      #1 resetn = 1'b0;
      #1 check_reset("midreset");
      check("runA_stream", pix_err, 0);
      check("runA_region", reg_err, 0);
      repeat (2) tick();
      resetn = 1'b1;
      tick();

      // Run B: table heights, stray start pulses during CLEAR and DRAW
      for (int i = 0; i < 8; i++) mem[vecs[i].addr] = vecs[i].hist;
      for (int x = 0; x < 320; x++)
         for (int y = 0; y <= 100; y++)
            fb[x][y] = 3'b111;
      clear_stats();
      push_chart();
      pulse_start(start_cyc);
      check("runB_busy", int'(busy), 1);
      repeat (100) tick();
      pulse_start(dummy_cyc);
      for (int k = 0; k < 40000 && bar_seen < 2; k++) tick();
      check("runB_reach_bar1", (bar_seen >= 2) ? 1 : 0, 1);
      repeat (5) tick();
      pulse_start(dummy_cyc);
      for (int k = 0; k < 50000 && done_cnt == 0; k++) tick();
      check("runB_done_seen", (done_cnt > 0) ? 1 : 0, 1);

      exp_len = 32320 + 1;
      for (int i = 0; i < 8; i++) exp_len += vecs[i].exp_plots + 4;
      check("runB_done_latency", done_cyc - start_cyc + 1, exp_len);
      repeat (20) tick();
      check("runB_one_done", done_cnt, 1);
      check("runB_busy_after", int'(busy), 0);
      check("runB_plot_idle", int'(vga_plot), 0);
      check("runB_stream", pix_err, 0);
      check("runB_queue_empty", sbq.size(), 0);
      check("runB_region", reg_err, 0);
      check("runB_bg_plots", bg_plots, 32320);
      check("runB_bars_seen", bar_seen, 8);

      for (int i = 0; i < 8; i++) begin
         b = vecs[i].addr;
         check($sformatf("bar%0d_start_x", b), cap_sx[b],    vecs[i].exp_sx);
         check($sformatf("bar%0d_start_y", b), cap_sy[b],    vecs[i].exp_sy);
         check($sformatf("bar%0d_height", b),  cap_h[b],     vecs[i].exp_h);
         check($sformatf("bar%0d_plots", b),   bar_plots[b], vecs[i].exp_plots);
      end

      fb_bad = 0;
      for (int x = 0; x < 320; x++) begin
         for (int y = 0; y <= 100; y++) begin
            b = x / 40;
            if ((x % 40) < 32 && (y + 100) >= 200 - clamp_model(mem[b])) gold = 3'b010;
            else gold = 3'b000;
            if (fb[x][y] != gold) fb_bad++;
         end
      end
      check("framebuffer", fb_bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
